// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin acceptor: FSM states, coin-type encoding,
// default timing constants and small helpers.
package coin_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDebounce,
      StEmit,
      StRelease,
      StJam
   } state_e;

   typedef enum logic [1:0] {
      CoinNone = 2'd0,
      CoinA    = 2'd1,
      CoinB    = 2'd2,
      CoinC    = 2'd3
   } coin_e;

   localparam int unsigned DefDebCycles = 4;
   localparam int unsigned DefGapCycles = 2;
   localparam int unsigned DefJamCycles = 64;

   function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                        input int unsigned z);
      int unsigned m;
      m = (x > y) ? x : y;
      return (m > z) ? m : z;
   endfunction

   // Sensor vector bit order is {c, b, a}.
   function automatic logic [2:0] coin_mask(input coin_e coin);
      logic [2:0] m;
      unique case (coin)
         CoinA:   m = 3'b001;
         CoinB:   m = 3'b010;
         CoinC:   m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic coin_e coin_from_mask(input logic [2:0] m);
      coin_e coin;
      unique case (m)
         3'b001:  coin = CoinA;
         3'b010:  coin = CoinB;
         3'b100:  coin = CoinC;
         default: coin = CoinNone;
      endcase
      return coin;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous sensor input.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes three slot sensors, debounces a single coin, emits one
// credit pulse or a reject, then waits for the slot to clear (flagging jams).
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DefDebCycles,
   parameter int unsigned GAP_CYCLES = DefGapCycles,
   parameter int unsigned JAM_CYCLES = DefJamCycles
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sens_a,
   input  logic       sens_b,
   input  logic       sens_c,
   input  logic       enable,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       reject,
   output logic       jam,
   output logic [7:0] coin_count
);

   localparam int unsigned CntW = $clog2(max3(DEB_CYCLES, GAP_CYCLES, JAM_CYCLES) + 1);
   localparam logic [CntW-1:0] DebL = CntW'(DEB_CYCLES);
   localparam logic [CntW-1:0] GapL = CntW'(GAP_CYCLES - 1);
   localparam logic [CntW-1:0] JamL = CntW'(JAM_CYCLES - 1);

   logic [2:0]      w_sync;
   logic [2:0]      w_mask;
   logic            w_any;
   logic            w_single;

   state_e          r_state;
   coin_e           r_coin;
   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] r_jam_cnt;
   logic            r_a;
   logic            r_b;
   logic            r_c;
   logic            r_reject;
   logic            r_jam;
   logic [7:0]      r_count;

   sync2 u_sync_a (.clk(clk), .reset(reset), .i_d(sens_a), .o_q(w_sync[0]));
   sync2 u_sync_b (.clk(clk), .reset(reset), .i_d(sens_b), .o_q(w_sync[1]));
   sync2 u_sync_c (.clk(clk), .reset(reset), .i_d(sens_c), .o_q(w_sync[2]));

   assign w_mask   = coin_mask(r_coin);
   assign w_any    = |w_sync;
   assign w_single = w_any && ((w_sync & (w_sync - 3'd1)) == 3'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_coin    <= CoinNone;
         r_cnt     <= '0;
         r_jam_cnt <= '0;
         r_a       <= 1'b0;
         r_b       <= 1'b0;
         r_c       <= 1'b0;
         r_reject  <= 1'b0;
         r_jam     <= 1'b0;
         r_count   <= 8'd0;
      end else begin
         r_a      <= 1'b0;
         r_b      <= 1'b0;
         r_c      <= 1'b0;
         r_reject <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_single) begin
                  r_coin  <= coin_from_mask(w_sync);
                  r_cnt   <= '0;
                  r_state <= StDebounce;
               end else if (w_any) begin
                  r_reject  <= 1'b1;
                  r_cnt     <= '0;
                  r_jam_cnt <= '0;
                  r_state   <= StRelease;
               end
            end
            StDebounce: begin
               // A second sensor appearing is treated as a foreign object, even on a glitch.
               if ((w_sync & ~w_mask) != 3'd0) begin
                  r_reject  <= 1'b1;
                  r_cnt     <= '0;
                  r_jam_cnt <= '0;
                  r_state   <= StRelease;
               end else if ((w_sync & w_mask) == 3'd0) begin
                  r_coin  <= CoinNone;
                  r_state <= StIdle;
               end else if (r_cnt == DebL) begin
                  r_cnt     <= '0;
                  r_jam_cnt <= '0;
                  if (enable) begin
                     r_a     <= w_mask[0];
                     r_b     <= w_mask[1];
                     r_c     <= w_mask[2];
                     r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                     r_state <= StEmit;
                  end else begin
                     r_reject <= 1'b1;
                     r_state  <= StRelease;
                  end
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StEmit: begin
               r_cnt     <= '0;
               r_jam_cnt <= '0;
               r_state   <= StRelease;
            end
            StRelease: begin
               if (!w_any) begin
                  r_jam_cnt <= '0;
                  if (r_cnt == GapL) begin
                     r_coin  <= CoinNone;
                     r_state <= StIdle;
                  end else begin
                     r_cnt <= r_cnt + CntW'(1);
                  end
               end else begin
                  r_cnt <= '0;
                  if (r_jam_cnt == JamL) begin
                     r_jam   <= 1'b1;
                     r_state <= StJam;
                  end else begin
                     r_jam_cnt <= r_jam_cnt + CntW'(1);
                  end
               end
            end
            StJam: begin
               if (!w_any) begin
                  if (r_cnt == GapL) begin
                     r_jam   <= 1'b0;
                     r_coin  <= CoinNone;
                     r_cnt   <= '0;
                     r_state <= StIdle;
                  end else begin
                     r_cnt <= r_cnt + CntW'(1);
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign a          = r_a;
   assign b          = r_b;
   assign c          = r_c;
   assign reject     = r_reject;
   assign jam        = r_jam;
   assign coin_count = r_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: vector table, directed corner sequences and
// randomized coins checked against an arithmetic timing model.
module tb_coin_acceptor;

   localparam int Deb = 4;
   localparam int Jam = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       sens_a, sens_b, sens_c;
   logic       enable;
   logic       a, b, c, reject, jam;
   logic [7:0] coin_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_count = 0;

   coin_acceptor dut (
      .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b), .sens_c(sens_c),
      .enable(enable), .a(a), .b(b), .c(c), .reject(reject), .jam(jam),
      .coin_count(coin_count)
   );

   always #5 clk = ~clk;

   // Pulse vector order {a, b, c, reject}; sensor mask order {a, b, c}.
   typedef struct {
      logic [2:0] mask;
      int         dur;
      logic       en;
      logic [3:0] pulse;
      int         off;
      int         inc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sens(input logic [2:0] m);
      {sens_a, sens_b, sens_c} = m;
   endtask

   // Cycle invariants: one-hot credit pulses, never back to back, never with reject or jam.
   logic prev_abc = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_abc = 1'b0;
      end else begin
         n_tests++;
         if ((int'(a) + int'(b) + int'(c) > 1) || ((a | b | c) && (reject || prev_abc)) ||
             (jam && (a | b | c | reject))) begin
            n_fail++;
            $display("FAIL invariant: got abc=%b%b%b rej=%b jam=%b prev=%b want exclusive",
                     a, b, c, reject, jam, prev_abc);
         end
         prev_abc = a | b | c;
      end
   end

   // Inserts one object on the sensors in mask for d cycles, then 10 clear cycles.
   task automatic run_coin(input logic [2:0] mask, input int d, input logic en,
                           output logic [3:0] pulse, output int off, output int n);
      logic [3:0] cur;
      pulse = 4'b0;
      off   = -1;
      n     = 0;
      set_sens(mask);
      enable = en;
      for (int i = 0; i < d + 10; i++) begin
         tick();
         cur = {a, b, c, reject};
         if (cur != 4'b0) begin
            if (n == 0) begin
               pulse = cur;
               off   = i;
            end
            n++;
         end
         set_sens((i + 1 < d) ? mask : 3'b000);
         if (i + 1 >= d + 3) enable = 1'($urandom);
      end
   endtask

   // Reference timing from the rules: sensor edge k is synced by k+2, needs DEB further
   // high samples, result registers at k+DEB+3; multiple sensors reject at k+2.
   task automatic predict(input logic [2:0] mask, input int d, input logic en,
                          output logic [3:0] pulse, output int off, output int inc);
      int ones;
      ones  = int'(mask[0]) + int'(mask[1]) + int'(mask[2]);
      pulse = 4'b0;
      off   = -1;
      inc   = 0;
      if (ones >= 2) begin
         pulse = 4'b0001;
         off   = 2;
      end else if (d >= Deb + 2) begin
         off   = Deb + 3;
         pulse = en ? {mask, 1'b0} : 4'b0001;
         inc   = en ? 1 : 0;
      end
   endtask

   initial begin
      logic [3:0] g_pulse, e_pulse;
      int         g_off, g_n, e_off, e_inc;
      int         jam_rise, jam_fall, a_off, rej_n;
      logic [2:0] m;
      int         d;
      logic       en;

      vecs[0] = '{3'b010, 10, 1'b1, 4'b0100, 7, 1};
      vecs[1] = '{3'b100, 2, 1'b1, 4'b0000, -1, 0};
      vecs[2] = '{3'b101, 10, 1'b1, 4'b0001, 2, 0};
      vecs[3] = '{3'b001, 10, 1'b0, 4'b0001, 7, 0};
      vecs[4] = '{3'b100, 6, 1'b1, 4'b1000, 7, 1};
      vecs[5] = '{3'b100, 5, 1'b1, 4'b0000, -1, 0};
      vecs[6] = '{3'b001, 8, 1'b1, 4'b0010, 7, 1};
      vecs[7] = '{3'b111, 4, 1'b1, 4'b0001, 2, 0};

      reset = 1'b0;
      enable = 1'b0;
      set_sens(3'b000);
      #1;
      chk("reset_outputs", int'({a, b, c, reject, jam}), 0);
      chk("reset_count", int'(coin_count), 0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      for (int v = 0; v < 8; v++) begin
         run_coin(vecs[v].mask, vecs[v].dur, vecs[v].en, g_pulse, g_off, g_n);
         exp_count += vecs[v].inc;
         chk($sformatf("vec%0d_pulse", v), int'(g_pulse), int'(vecs[v].pulse));
         chk($sformatf("vec%0d_offset", v), g_off, vecs[v].off);
         chk($sformatf("vec%0d_npulse", v), g_n, (vecs[v].pulse != 4'b0) ? 1 : 0);
         chk($sformatf("vec%0d_count", v), int'(coin_count), exp_count);
      end

      // Reset landing on the EMIT cycle kills the pulse at once.
      set_sens(3'b010);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("emit_b_before_reset", int'(b), 1);
      reset = 1'b0;
      #1;
      chk("emit_b_after_reset", int'(b), 0);
      chk("emit_count_after_reset", int'(coin_count), 0);
      exp_count = 0;
      set_sens(3'b000);
      tick();
      reset = 1'b1;
      tick();
      chk("first_cycle_after_reset", int'({a, b, c, reject}), 0);
      for (int i = 0; i < 6; i++) tick();

      // Sensor held long enough to jam.
      jam_rise = -1;
      jam_fall = -1;
      a_off = -1;
      rej_n = 0;
      set_sens(3'b100);
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (a && a_off < 0) a_off = i;
         if (reject) rej_n++;
         if (jam && jam_rise < 0) jam_rise = i;
         if (!jam && jam_rise >= 0 && jam_fall < 0) jam_fall = i;
         set_sens((i + 1 < 80) ? 3'b100 : 3'b000);
      end
      exp_count += 1;
      chk("jam_a_offset", a_off, 7);
      chk("jam_rise", jam_rise, 7 + 1 + Jam);
      chk("jam_fall", jam_fall, 83);
      chk("jam_no_reject", rej_n, 0);
      chk("jam_count", int'(coin_count), exp_count);

      for (int r = 0; r < 40; r++) begin
         m = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 3) != 0) m = 3'b001 << $urandom_range(0, 2);
         d  = $urandom_range(1, 50);
         en = 1'($urandom);
         predict(m, d, en, e_pulse, e_off, e_inc);
         run_coin(m, d, en, g_pulse, g_off, g_n);
         if (exp_count + e_inc <= 255) exp_count += e_inc;
         chk($sformatf("rnd%0d_m%b_d%0d_e%b_pulse", r, m, d, en), int'(g_pulse), int'(e_pulse));
         chk($sformatf("rnd%0d_offset", r), g_off, e_off);
         chk($sformatf("rnd%0d_npulse", r), g_n, (e_pulse != 4'b0) ? 1 : 0);
         chk($sformatf("rnd%0d_count", r), int'(coin_count), exp_count);
      end

      // Saturation: restart from reset, 256 coins, then reset during the 257th.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         run_coin(3'b001, 8, 1'b1, g_pulse, g_off, g_n);
         if (i == 254) chk("count_255", int'(coin_count), 255);
      end
      chk("count_saturated", int'(coin_count), 255);
      set_sens(3'b100);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      #1;
      chk("sat_reset_count", int'(coin_count), 0);
      chk("sat_reset_outputs", int'({a, b, c, reject, jam}), 0);
      tick();
      tick();
      reset = 1'b1;
      g_off = -1;
      g_n = 0;
      g_pulse = 4'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if ({a, b, c, reject} != 4'b0) begin
            if (g_n == 0) begin
               g_off = i;
               g_pulse = {a, b, c, reject};
            end
            g_n++;
         end
      end
      set_sens(3'b000);
      for (int i = 0; i < 6; i++) tick();
      chk("held_sensor_offset", g_off, 7);
      chk("held_sensor_pulse", int'(g_pulse), int'(4'b1000));
      chk("held_sensor_npulse", g_n, 1);
      chk("held_sensor_count", int'(coin_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
